// File: rtl/signed_divider_frontend.sv
// Request/response front end for the unsigned non-restoring divider core: resolves trivial cases
// locally, launches the core on magnitudes and sign-corrects its result. Define DIV_SIGNED_EN for signed support.
module signed_divider_frontend #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  clk_en_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [DATA_WIDTH-1:0] dividend_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    input  logic                  signed_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] quotient_o,
    output logic [DATA_WIDTH-1:0] remainder_o,
    output logic                  divide_by_zero_o,
    output logic                  overflow_o,
    output logic [DATA_WIDTH-1:0] core_dividend_o,
    output logic [DATA_WIDTH-1:0] core_divisor_o,
    output logic                  core_valid_o,
    input  logic                  core_idle_i,
    input  logic                  core_valid_i,
    input  logic [DATA_WIDTH-1:0] core_quotient_i,
    input  logic [DATA_WIDTH-1:0] core_remainder_i
);
    localparam int W = DATA_WIDTH;
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   quot_q, quot_d;
    logic [W-1:0]   rem_q, rem_d;
    logic           dbz_q, dbz_d;
    logic           ovf_q, ovf_d;
    logic [W-1:0]   mag_a_q, mag_a_d;
    logic [W-1:0]   mag_b_q, mag_b_d;
    logic           launch;

    logic [W-1:0]   mag_a, mag_b;
    logic           ovf_hit;
    logic [W-1:0]   core_q_fixed, core_r_fixed;

`ifdef DIV_SIGNED_EN
    logic           neg_a, neg_b;
    logic           neg_a_q, neg_b_q;

    function automatic logic [W-1:0] negate(input logic [W-1:0] x);
        return (~x) + {{(W-1){1'b0}}, 1'b1};
    endfunction

    assign neg_a        = signed_i & dividend_i[W-1];
    assign neg_b        = signed_i & divisor_i[W-1];
    assign mag_a        = neg_a ? negate(dividend_i) : dividend_i;
    assign mag_b        = neg_b ? negate(divisor_i) : divisor_i;
    assign ovf_hit      = signed_i & (dividend_i == MIN_VAL) & (divisor_i == '1);
    assign core_q_fixed = (neg_a_q ^ neg_b_q) ? negate(core_quotient_i) : core_quotient_i;
    assign core_r_fixed = neg_a_q ? negate(core_remainder_i) : core_remainder_i;

    // Sign flags are captured alongside the operands on every accept.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
        end else if (clk_en_i && state_q == IDLE && req_valid_i) begin
            neg_a_q <= neg_a;
            neg_b_q <= neg_b;
        end
    end
`else
    logic           unused_signed;

    assign unused_signed = signed_i;
    assign mag_a         = dividend_i;
    assign mag_b         = divisor_i;
    assign ovf_hit       = 1'b0;
    assign core_q_fixed  = core_quotient_i;
    assign core_r_fixed  = core_remainder_i;
`endif

    always_comb begin
        state_d = state_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        mag_a_d = mag_a_q;
        mag_b_d = mag_b_q;
        launch  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    mag_a_d = mag_a;
                    mag_b_d = mag_b;
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                    if (divisor_i == '0) begin
                        quot_d  = '1;
                        rem_d   = dividend_i;
                        dbz_d   = 1'b1;
                        state_d = RESPOND;
                    end else if (ovf_hit) begin
                        quot_d  = MIN_VAL;
                        rem_d   = '0;
                        ovf_d   = 1'b1;
                        state_d = RESPOND;
                    end else if (mag_a < mag_b) begin
                        quot_d  = '0;
                        rem_d   = dividend_i;
                        state_d = RESPOND;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (core_idle_i) begin
                    launch  = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (core_valid_i) begin
                    quot_d  = core_q_fixed;
                    rem_d   = core_r_fixed;
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = RESPOND;
                end
            end
            RESPOND: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            mag_a_q <= '0;
            mag_b_q <= '0;
        end else if (clk_en_i) begin
            state_q <= state_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
        end
    end

    // The start pulse only counts on an enabled, non-reset edge, so it is qualified here.
    assign core_valid_o     = launch & clk_en_i & rst_n_i;
    assign req_ready_o      = (state_q == IDLE);
    assign rsp_valid_o      = (state_q == RESPOND);
    assign quotient_o       = quot_q;
    assign remainder_o      = rem_q;
    assign divide_by_zero_o = dbz_q;
    assign overflow_o       = ovf_q;
    assign core_dividend_o  = mag_a_q;
    assign core_divisor_o   = mag_b_q;

endmodule

// File: tb/tb_signed_divider_frontend.sv
// Bench for signed_divider_frontend: directed vectors, a 16-cycle core model and an arithmetic reference model.
module tb_signed_divider_frontend;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n_i, clk_en_i, req_valid_i, req_ready_o, signed_i;
    logic [W-1:0]  dividend_i, divisor_i, quotient_o, remainder_o;
    logic          rsp_valid_o, rsp_ready_i, divide_by_zero_o, overflow_o;
    logic [W-1:0]  core_dividend_o, core_divisor_o, core_quotient_i, core_remainder_i;
    logic          core_valid_o, core_idle_i, core_valid_i;

    int            n_chk = 0, n_pass = 0;
    logic          pending = 1'b0;
    logic [W-1:0]  exp_q, exp_r;
    logic          exp_dbz, exp_ovf, exp_early;
    logic          cv1;
    logic [W-1:0]  cd1, cdv1;
    int            stray_req = 0;

    always #5 clk = ~clk;

    signed_divider_frontend #(.DATA_WIDTH(W)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .clk_en_i(clk_en_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .dividend_i(dividend_i), .divisor_i(divisor_i), .signed_i(signed_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .quotient_o(quotient_o), .remainder_o(remainder_o),
        .divide_by_zero_o(divide_by_zero_o), .overflow_o(overflow_o),
        .core_dividend_o(core_dividend_o), .core_divisor_o(core_divisor_o),
        .core_valid_o(core_valid_o), .core_idle_i(core_idle_i), .core_valid_i(core_valid_i),
        .core_quotient_i(core_quotient_i), .core_remainder_i(core_remainder_i)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Reference: plain integer division (truncating, remainder follows dividend) plus the special cases.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dbz, output logic ovf, output logic early);
        longint sa, sb, qi, ri;
        logic se;
`ifdef DIV_SIGNED_EN
        se = s;
`else
        se = 1'b0;
`endif
        dbz = 1'b0;
        ovf = 1'b0;
        if (b == 0) begin
            q = '1; r = a; dbz = 1'b1; early = 1'b1;
        end else if (se && a == 16'h8000 && b == 16'hFFFF) begin
            q = 16'h8000; r = '0; ovf = 1'b1; early = 1'b1;
        end else begin
            if (se) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'(a);
                sb = longint'(b);
            end
            qi = sa / sb;
            ri = sa % sb;
            q = qi[W-1:0];
            r = ri[W-1:0];
            early = ((sa < 0) ? -sa : sa) < ((sb < 0) ? -sb : sb);
        end
    endtask

    // Core model: 16-cycle latency from the start pulse; also emits stray result pulses on request.
    initial begin : core_model
        int cnt;
        int stray_done;
        logic [W-1:0] ca, cb;
        cnt = 0; stray_done = 0; ca = '0; cb = '1;
        core_valid_i = 1'b0; core_idle_i = 1'b1;
        core_quotient_i = '0; core_remainder_i = '0;
        forever begin
            @(negedge clk);
            core_valid_i = 1'b0;
            if (!rst_n_i) begin
                cnt = 0;
                core_idle_i = 1'b1;
            end else if (cnt > 0) begin
                core_idle_i = 1'b0;
                cnt--;
                if (cnt == 0) begin
                    core_valid_i = 1'b1;
                    core_quotient_i = ca / cb;
                    core_remainder_i = ca % cb;
                    core_idle_i = 1'b1;
                end
            end else if (core_valid_o && clk_en_i) begin
                ca = core_dividend_o;
                cb = core_divisor_o;
                cnt = 17;
            end else if (stray_done < stray_req) begin
                core_valid_i = 1'b1;
                core_quotient_i = 16'h1234;
                core_remainder_i = 16'h5678;
                stray_done++;
            end
        end
    end

    // Compare process: every cycle out of reset, outputs against the reference model.
    initial begin : compare
        forever begin
            @(negedge clk);
            if (rst_n_i) begin
                if (!pending) begin
                    check("idle_rsp_valid", rsp_valid_o, 1'b0);
                    check("idle_req_ready", req_ready_o, 1'b1);
                end else if (rsp_valid_o) begin
                    check("cmp_quotient", quotient_o, exp_q);
                    check("cmp_remainder", remainder_o, exp_r);
                    check("cmp_dbz", divide_by_zero_o, exp_dbz);
                    check("cmp_ovf", overflow_o, exp_ovf);
                    check("cmp_req_ready_low", req_ready_o, 1'b0);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        model(a, b, s, exp_q, exp_r, exp_dbz, exp_ovf, exp_early);
        pending = 1'b1;
        req_valid_i = 1'b1; dividend_i = a; divisor_i = b; signed_i = s;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        cv1 = core_valid_o; cd1 = core_dividend_o; cdv1 = core_divisor_o;
    endtask

    task automatic wait_rsp(output int lat, output int pulses);
        int cyc;
        cyc = 1; lat = -1; pulses = 0;
        while (lat < 0 && cyc < 60) begin
            if (core_valid_o) pulses++;
            if (rsp_valid_o) lat = cyc;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (lat < 0) check("rsp_timeout", rsp_valid_o, 1'b1);
    endtask

    task automatic release_rsp();
        rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        rsp_ready_i = 1'b0;
        pending = 1'b0;
        check("req_ready_after_rsp", req_ready_o, 1'b1);
        check("rsp_valid_after_rsp", rsp_valid_o, 1'b0);
    endtask

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input string tag);
        int lat, pulses;
        issue(a, b, s);
        wait_rsp(lat, pulses);
        check({tag, "_latency"}, lat, exp_early ? 1 : W + 3);
        check({tag, "_core_pulses"}, pulses, exp_early ? 0 : 1);
        check({tag, "_core_valid_c1"}, cv1, !exp_early);
        release_rsp();
    endtask

    initial begin : stimulus
        rst_n_i = 1'b0; clk_en_i = 1'b1; req_valid_i = 1'b0; rsp_ready_i = 1'b0;
        dividend_i = '0; divisor_i = '0; signed_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready_o, 1'b1);
        check("rst_rsp_valid", rsp_valid_o, 1'b0);
        check("rst_core_valid", core_valid_o, 1'b0);
        check("rst_quotient", quotient_o, 16'h0);
        check("rst_remainder", remainder_o, 16'h0);
        check("rst_flags", {divide_by_zero_o, overflow_o}, 2'b00);
        check("rst_core_ops", {core_dividend_o, core_divisor_o}, 32'h0);
        rst_n_i = 1'b1;
        @(posedge clk); #1;

        run(16'd100, 16'd7, 1'b0, "u100_7");
        check("u100_7_core_ops", {cd1, cdv1}, {16'd100, 16'd7});
        check("u100_7_q", quotient_o, 16'd14);
        check("u100_7_r", remainder_o, 16'd2);
        check("u100_7_flags", {divide_by_zero_o, overflow_o}, 2'b00);

        run(16'hFFF9, 16'h0002, 1'b1, "s_m7_2");
`ifdef DIV_SIGNED_EN
        check("s_m7_2_core_ops", {cd1, cdv1}, {16'd7, 16'd2});
        check("s_m7_2_q", quotient_o, 16'hFFFD);
        check("s_m7_2_r", remainder_o, 16'hFFFF);
`else
        check("s_m7_2_core_ops", {cd1, cdv1}, {16'hFFF9, 16'd2});
        check("s_m7_2_q", quotient_o, 16'h7FFC);
        check("s_m7_2_r", remainder_o, 16'h0001);
`endif

        run(16'd1234, 16'd0, 1'b0, "dbz");
        check("dbz_q", quotient_o, 16'hFFFF);
        check("dbz_r", remainder_o, 16'd1234);
        check("dbz_flag", divide_by_zero_o, 1'b1);

        run(16'h8000, 16'hFFFF, 1'b1, "ovf");
`ifdef DIV_SIGNED_EN
        check("ovf_q", quotient_o, 16'h8000);
        check("ovf_r", remainder_o, 16'h0000);
        check("ovf_flag", overflow_o, 1'b1);
`else
        check("ovf_q", quotient_o, 16'h0000);
        check("ovf_r", remainder_o, 16'h8000);
        check("ovf_flag", overflow_o, 1'b0);
`endif

        run(16'hFF9C, 16'd7, 1'b1, "s_m100_7");
        run(16'd100, 16'hFFF9, 1'b1, "s_100_m7");
        run(16'hFFFF, 16'hFFFF, 1'b0, "u_max_max");

        // Held response: back-pressure, then a frozen clock enable, then release.
        begin
            int lat, pulses;
            issue(16'd5, 16'd9, 1'b0);
            wait_rsp(lat, pulses);
            check("hold_latency", lat, 1);
            for (int i = 0; i < 3; i++) begin
                check("hold_req_ready", req_ready_o, 1'b0);
                check("hold_rsp_valid", rsp_valid_o, 1'b1);
                check("hold_q", quotient_o, 16'd0);
                check("hold_r", remainder_o, 16'd5);
                @(posedge clk); #1;
            end
            clk_en_i = 1'b0;
            rsp_ready_i = 1'b1;
            for (int i = 0; i < 2; i++) begin
                @(posedge clk); #1;
                check("freeze_rsp_valid", rsp_valid_o, 1'b1);
            end
            clk_en_i = 1'b1;
            @(posedge clk); #1;
            rsp_ready_i = 1'b0;
            pending = 1'b0;
            check("hold_idle_req_ready", req_ready_o, 1'b1);
            check("hold_idle_rsp_valid", rsp_valid_o, 1'b0);
        end

        // Reset while waiting on the core, then a stray core result.
        issue(16'd200, 16'd3, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("wait_no_rsp", rsp_valid_o, 1'b0);
        rst_n_i = 1'b0;
        @(posedge clk); #1;
        rst_n_i = 1'b1;
        pending = 1'b0;
        check("rstwait_rsp_valid", rsp_valid_o, 1'b0);
        check("rstwait_req_ready", req_ready_o, 1'b1);
        check("rstwait_core_valid", core_valid_o, 1'b0);
        stray_req = 1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("stray_rsp_valid", rsp_valid_o, 1'b0);
        end

        run(16'd300, 16'd10, 1'b0, "post_reset");
        check("post_reset_q", quotient_o, 16'd30);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/signed_divider_frontend.md
# signed_divider_frontend

Request/response sequencing stage placed directly in front of the unsigned non-restoring divider core. It accepts signed or unsigned operand pairs over a valid/ready handshake, resolves divide-by-zero, signed overflow and |dividend| < |divisor| locally, and otherwise converts operands to magnitudes and launches the core. When the core finishes, it captures the result, applies sign correction, and holds the response until it is consumed.

## Interface
- DATA_WIDTH, 16, operand/result width; must be a power of 2 and equal to the core's DATA_WIDTH.

- clk_i  in  1  clock.
- rst_n_i  in  1  reset, synchronous, active-low.
- clk_en_i  in  1  clock enable; when low, all registers hold. Must be shared with the core.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready; high only in IDLE.
- dividend_i  in  DATA_WIDTH  dividend.
- divisor_i  in  DATA_WIDTH  divisor.
- signed_i  in  1  1 = operands are two's complement.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response accepted.
- quotient_o  out  DATA_WIDTH  final quotient.
- remainder_o  out  DATA_WIDTH  final remainder.
- divide_by_zero_o  out  1  divisor was 0.
- overflow_o  out  1  signed MIN / -1.
- core_dividend_o  out  DATA_WIDTH  magnitude dividend sent to the core.
- core_divisor_o  out  DATA_WIDTH  magnitude divisor sent to the core.
- core_valid_o  out  1  one-cycle start pulse to the core.
- core_idle_i  in  1  core idle flag.
- core_valid_i  in  1  core result valid.
- core_quotient_i  in  DATA_WIDTH  core quotient.
- core_remainder_i  in  DATA_WIDTH  core remainder.

## Operation
- State machine: IDLE, ISSUE, WAIT, RESPOND.
- Reset values:
  - State: IDLE.
  - Zero: rsp_valid_o, core_valid_o, quotient_o, remainder_o, divide_by_zero_o, overflow_o, core_dividend_o, core_divisor_o.
  - req_ready_o: 1.
- IDLE, on accept (req_valid_i & req_ready_o):
  - Register operands and sign flags: neg_a = signed_i & dividend[MSB]; neg_b = signed_i & divisor[MSB].
  - Register magnitudes: |x| = two's-complement negate when negative. |MIN| = 2^(W-1) as an unsigned value.
  - Resolve in priority order:
    - divisor == 0: quotient = all ones, remainder = original dividend, divide_by_zero_o = 1. Go to RESPOND.
    - signed_i & dividend == 0x8..0 & divisor == all ones: quotient = 0x8..0, remainder = 0, overflow_o = 1. Go to RESPOND.
    - |dividend| < |divisor| (unsigned compare): quotient = 0, remainder = original dividend. Go to RESPOND.
    - Otherwise go to ISSUE.
- ISSUE:
  - Drive core_dividend_o / core_divisor_o with the magnitudes; hold them stable until the next accept.
  - When core_idle_i = 1, assert core_valid_o for exactly one cycle and go to WAIT. Otherwise stay in ISSUE.
- WAIT, on core_valid_i:
  - quotient = neg_a ^ neg_b ? -core_quotient_i : core_quotient_i.
  - remainder = neg_a ? -core_remainder_i : core_remainder_i.
  - Both flags 0. Go to RESPOND.
- RESPOND:
  - rsp_valid_o = 1; all result outputs held stable.
  - On rsp_ready_i, go to IDLE.
- Arithmetic is modulo 2^DATA_WIDTH. Quotient truncates toward zero; the remainder takes the dividend's sign.
- core_valid_i outside WAIT is ignored.
- No request is accepted in the same cycle as a response handshake; the next accept is at the earliest one cycle later.

## Timing
- Cycle 0 = accept edge.
- Early-out path: rsp_valid_o high from cycle 1.
- Core path with core_idle_i high:
  - core_valid_o in cycle 1.
  - Core result (core_valid_i) in cycle DATA_WIDTH+2.
  - rsp_valid_o from cycle DATA_WIDTH+3 (19 for DATA_WIDTH = 16).
- clk_en_i low freezes state, outputs and the latency count.
- Reset asserted in any state:
  - Next cycle: IDLE, rsp_valid_o = 0, core_valid_o = 0.
  - The core must be reset by the same rst_n_i.

## Configuration
- DIV_SIGNED_EN defined:
  - signed_i is honoured.
  - Magnitude conversion, sign correction and overflow detection are built.
- DIV_SIGNED_EN undefined:
  - signed_i is ignored (treated as 0).
  - neg_a/neg_b are constant 0 and overflow_o is tied 0.
  - No negation logic is built; all other behaviour is unchanged.

## Test plan
- Unsigned 100 / 7, core modelled with 16-cycle latency -> core_valid_o at cycle 1, rsp_valid_o at cycle 19, q = 14, r = 2, flags 0.
- Signed 0xFFF9 / 0x0002 (-7 / 2) -> core sees 7 / 2; response q = 0xFFFD, r = 0xFFFF.
- 1234 / 0 -> rsp_valid_o at cycle 1, q = 0xFFFF, r = 1234, divide_by_zero_o = 1, core_valid_o never asserted.
- Signed 0x8000 / 0xFFFF -> q = 0x8000, r = 0, overflow_o = 1 at cycle 1. With DIV_SIGNED_EN undefined: q = 0, r = 0x8000, overflow_o = 0.
- 5 / 9 with rsp_ready_i low for 3 cycles -> q = 0, r = 5; outputs stable and req_ready_o = 0 throughout; IDLE the cycle after rsp_ready_i rises.
- rst_n_i low for one cycle while in WAIT -> next cycle rsp_valid_o = 0 and req_ready_o = 1; a stray core_valid_i pulse afterwards produces no response.
